// File: rtl/sensor_reg_reader.sv
// Sweeps the sensor register file and frames the bytes as a telemetry packet
// on a valid/ready byte stream. Define SENSOR_READER_CHKSUM_EN to append a checksum byte.
module sensor_reg_reader #(
  parameter int         FIRST_ADDR = 1,
  parameter int         LAST_ADDR  = 25,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic [7:0] addr,
  input  logic [7:0] data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       pkt_done,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] LEN_BYTE = 8'(LAST_ADDR - FIRST_ADDR + 1);
  localparam logic [7:0] FIRST_A  = 8'(FIRST_ADDR);
  localparam logic [7:0] LAST_A   = 8'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE, SYNC, LEN, FETCH, SEND
`ifdef SENSOR_READER_CHKSUM_EN
    , CHK
`endif
  } state_t;

  // Stream handshake: a byte moves only on a rising edge with tx_valid & tx_ready;
  // while tx_valid is high and unaccepted, tx_data and tx_valid are held.
  state_t     state, state_d;
  logic [7:0] addr_d, tx_data_d, drop_d;
  logic       tx_valid_d, pkt_done_d;
  logic       accept;

`ifdef SENSOR_READER_CHKSUM_EN
  logic [7:0] sum, sum_d;
`endif

  assign accept = tx_valid & tx_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    state_d    = state;
    addr_d     = addr;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    pkt_done_d = 1'b0;
`ifdef SENSOR_READER_CHKSUM_EN
    sum_d      = sum;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_d    = SYNC;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
`ifdef SENSOR_READER_CHKSUM_EN
          sum_d      = 8'd0;
`endif
        end
      end
      SYNC: begin
        if (accept) begin
          state_d   = LEN;
          tx_data_d = LEN_BYTE;
        end
      end
      LEN: begin
        if (accept) begin
          state_d    = FETCH;
          addr_d     = FIRST_A;
          tx_valid_d = 1'b0;
        end
      end
      // One dead cycle so data has settled from the registered addr.
      FETCH: begin
        state_d    = SEND;
        tx_data_d  = data;
        tx_valid_d = 1'b1;
`ifdef SENSOR_READER_CHKSUM_EN
        sum_d      = sum + data;
`endif
      end
      SEND: begin
        if (accept) begin
          if (addr != LAST_A) begin
            state_d    = FETCH;
            addr_d     = addr + 8'd1;
            tx_valid_d = 1'b0;
          end else begin
`ifdef SENSOR_READER_CHKSUM_EN
            state_d   = CHK;
            tx_data_d = (~sum) + 8'd1;
`else
            state_d    = IDLE;
            addr_d     = 8'd0;
            tx_valid_d = 1'b0;
            pkt_done_d = 1'b1;
`endif
          end
        end
      end
`ifdef SENSOR_READER_CHKSUM_EN
      CHK: begin
        if (accept) begin
          state_d    = IDLE;
          addr_d     = 8'd0;
          tx_valid_d = 1'b0;
          pkt_done_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d    = IDLE;
        addr_d     = 8'd0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    drop_d = drop_cnt;
    if (start && (state != IDLE) && (drop_cnt != 8'hFF)) drop_d = drop_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= 8'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      pkt_done <= 1'b0;
      drop_cnt <= 8'd0;
`ifdef SENSOR_READER_CHKSUM_EN
      sum      <= 8'd0;
`endif
    end else begin
      state    <= state_d;
      addr     <= addr_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      pkt_done <= pkt_done_d;
      drop_cnt <= drop_d;
`ifdef SENSOR_READER_CHKSUM_EN
      sum      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_sensor_reg_reader.sv
// Bench for sensor_reg_reader: packet-level model on the default instance plus
// directed cycle checks, and a single-address instance for the short-packet case.
module tb_sensor_reg_reader;

`ifdef SENSOR_READER_CHKSUM_EN
  localparam int DONE_CYC = 54;
`else
  localparam int DONE_CYC = 53;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, tx_ready1 = 1'b0;
  logic       busy1, tx_valid1, pkt_done1;
  logic [7:0] addr1, data1, tx_data1, drop1;
  logic       start2 = 1'b0, tx_ready2 = 1'b0;
  logic       busy2, tx_valid2, pkt_done2;
  logic [7:0] addr2, data2, tx_data2, drop2;

  // Register files: first holds value = address, second returns 0x80 everywhere.
  assign data1 = addr1;
  assign data2 = 8'h80;

  sensor_reg_reader dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .addr(addr1), .data(data1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .pkt_done(pkt_done1), .drop_cnt(drop1)
  );

  sensor_reg_reader #(.FIRST_ADDR(4), .LAST_ADDR(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .addr(addr2), .data(data2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .pkt_done(pkt_done2), .drop_cnt(drop2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done1  = 0;
  logic [7:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet model: sync, length, bytes equal to their addresses, then the byte
  // that brings the payload sum to zero mod 256.
  task automatic push_pkt1();
    int s;
    s = 0;
    exp_q1.push_back(8'hA5);
    exp_q1.push_back(8'd25);
    for (int a = 1; a <= 25; a++) begin
      exp_q1.push_back(8'(a));
      s += a;
    end
`ifdef SENSOR_READER_CHKSUM_EN
    exp_q1.push_back(8'((256 - (s % 256)) % 256));
`endif
  endtask

  // Compare process: every accepted byte against the model, hold-stability of
  // stalled bytes, and that pkt_done lands only after the whole packet.
  initial begin : monitor
    logic       hold;
    logic [7:0] held;
    hold = 1'b0;
    held = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", tx_valid1, 1);
          check("stall_data", tx_data1, held);
        end
        if (tx_valid1 && tx_ready1) begin
          if (exp_q1.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_byte: got %0h expected no byte at %0t", tx_data1, $time);
          end else begin
            check("stream_byte", tx_data1, exp_q1.pop_front());
          end
          hold = 1'b0;
        end else begin
          hold = tx_valid1;
          held = tx_data1;
        end
        if (pkt_done1) begin
          n_done1++;
          check("done_all_sent", exp_q1.size(), 0);
          check("done_not_busy", busy1, 0);
        end
      end
    end
  end

  task automatic check_reset1();
    check("rst_busy", busy1, 0);
    check("rst_addr", addr1, 0);
    check("rst_tx_data", tx_data1, 0);
    check("rst_tx_valid", tx_valid1, 0);
    check("rst_pkt_done", pkt_done1, 0);
    check("rst_drop", drop1, 0);
  endtask

  // Called #1 after a rising edge; returns #1 after the start edge (cycle 1).
  task automatic pulse_start1();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic run_wait(input int max, input bit rnd, output int cyc);
    cyc = 0;
    while (!pkt_done1 && cyc < max) begin
      @(posedge clk); #1;
      if (rnd) tx_ready1 = ($urandom_range(0, 99) < 30);
      cyc++;
    end
    check("done_timeout", pkt_done1, 1);
  endtask

  initial begin : main
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check_reset1();
    check("rst2_valid", tx_valid2, 0);
    check("rst2_busy", busy2, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full packet, ready tied high, with cycle-exact literal pins.
    tx_ready1 = 1'b1;
    push_pkt1();
    pulse_start1();
    cyc = 1;
    check("c1_busy", busy1, 1);
    check("c1_valid", tx_valid1, 1);
    check("c1_sync", tx_data1, 8'hA5);
    while (!pkt_done1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) check("c2_len", tx_data1, 8'h19);
      if (cyc == 3) begin
        check("c3_addr", addr1, 8'h01);
        check("c3_valid", tx_valid1, 0);
      end
      if (cyc == 4) check("c4_byte0", tx_data1, 8'h01);
      if (cyc == 52) check("c52_last", tx_data1, 8'h19);
`ifdef SENSOR_READER_CHKSUM_EN
      if (cyc == 53) check("c53_chk", tx_data1, 8'hBB);
`endif
    end
    check("done_cycle", cyc, DONE_CYC);
    check("done_addr_idle", addr1, 0);
    @(posedge clk); #1;
    check("done_one_cycle", pkt_done1, 0);
    check("drop_still_zero", drop1, 0);

    // Random back-pressure: model checks sequence and stall stability.
    push_pkt1();
    tx_ready1 = 1'b0;
    pulse_start1();
    run_wait(3000, 1'b1, cyc);
    tx_ready1 = 1'b1;
    @(posedge clk); #1;

    // 300 dropped requests while stalled in SYNC.
    push_pkt1();
    tx_ready1 = 1'b0;
    pulse_start1();
    for (int i = 0; i < 300; i++) begin
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(posedge clk); #1;
      if (i == 9) check("drop_10", drop1, 10);
    end
    check("drop_sat", drop1, 255);
    check("drop_still_sync", tx_data1, 8'hA5);
    tx_ready1 = 1'b1;
    run_wait(200, 1'b0, cyc);
    check("drop_pkt_cycles", cyc, DONE_CYC - 1);
    check("drop_held", drop1, 255);
    @(posedge clk); #1;

    // Reset during payload byte 10, then a clean packet.
    push_pkt1();
    pulse_start1();
    repeat (22) @(posedge clk);
    #1;
    check("b10_addr", addr1, 8'd11);
    rst = 1'b1;
    #1;
    check_reset1();
    exp_q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", pkt_done1, 0);
    end
    push_pkt1();
    pulse_start1();
    check("restart_sync", tx_data1, 8'hA5);
    run_wait(200, 1'b0, cyc);
    check("restart_cycles", cyc, DONE_CYC - 1);

    // Single-address instance: A5, 01, 80 (, 80).
    tx_ready2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("s1_sync", tx_data2, 8'hA5);
    check("s1_valid", tx_valid2, 1);
    @(posedge clk); #1;
    check("s2_len", tx_data2, 8'h01);
    @(posedge clk); #1;
    check("s3_addr", addr2, 8'h04);
    check("s3_valid", tx_valid2, 0);
    @(posedge clk); #1;
    check("s4_byte", tx_data2, 8'h80);
    check("s4_valid", tx_valid2, 1);
    @(posedge clk); #1;
`ifdef SENSOR_READER_CHKSUM_EN
    check("s5_chk", tx_data2, 8'h80);
    check("s5_valid", tx_valid2, 1);
    check("s5_no_done", pkt_done2, 0);
    @(posedge clk); #1;
`endif
    check("s_done", pkt_done2, 1);
    check("s_idle", busy2, 0);
    check("s_drop", drop2, 0);

    check("done_count", n_done1, 4);
    check("model_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_reg_reader.md
# sensor_reg_reader

Packet initiator on the read side of the sensor register file. On a `start` request it sweeps the register file's byte-address range, fetching one byte per address through the `addr`/`data` read port. It frames the bytes as a telemetry packet: sync, length, payload and an optional checksum. The packet goes out as a valid/ready byte stream to the downstream UART/radio transmitter.

## Interface
Parameters:
- `FIRST_ADDR`, default 1, first register-file address read.
- `LAST_ADDR`, default 25, last address read. Constraints: `LAST_ADDR >= FIRST_ADDR`, `LAST_ADDR - FIRST_ADDR + 1 <= 255`.
- `SYNC_BYTE`, default 8'hA5, packet header byte.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  packet request, sampled on `clk` rising edge.
- `busy`  out  1  high from packet acceptance until return to IDLE.
- `addr`  out  8  register-file read address.
- `data`  in  8  register-file read data; combinational function of `addr`.
- `tx_data`  out  8  outgoing byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  downstream accepts the byte.
- `pkt_done`  out  1  one-cycle pulse after the final byte is accepted.
- `drop_cnt`  out  8  saturating count of `start` requests ignored while busy.

## Operation
- Packet layout: `SYNC_BYTE`, then LEN = `LAST_ADDR-FIRST_ADDR+1`, then LEN payload bytes in address order, then CHK (only when the checksum is configured in).
- The FSM has states IDLE, SYNC, LEN, FETCH, SEND, CHK.
- **IDLE** (busy=0, addr=0, tx_valid=0):
  - `start`=1 → SYNC.
  - Same edge: load tx_data=`SYNC_BYTE`, set tx_valid=1, clear sum.
- **SYNC**: on accept (tx_valid & tx_ready) → LEN; load tx_data=LEN; tx_valid stays 1.
- **LEN**: on accept → FETCH; addr=`FIRST_ADDR`; tx_valid=0.
- **FETCH** (one cycle, lets `data` settle from the registered `addr`):
  - Next edge: tx_data=`data`, tx_valid=1, sum=sum+`data` (mod 256).
  - → SEND.
- **SEND**: on accept:
  - If addr≠`LAST_ADDR`: addr=addr+1, tx_valid=0 → FETCH.
  - If addr=`LAST_ADDR`: go to CHK (checksum in) or finish (checksum out).
- **CHK**: tx_data=(~sum)+1, tx_valid=1; on accept → finish.
- **Finish**: state IDLE, addr=0, tx_valid=0, busy=0, `pkt_done`=1 for exactly one cycle.
- Handshake rules:
  - A transfer occurs only on a rising edge with tx_valid & tx_ready.
  - While tx_valid=1 and not accepted, tx_data and tx_valid are held stable.
  - tx_ready is ignored while tx_valid=0.
  - Downstream may hold tx_ready low indefinitely; the FSM waits with no timeout.
- `start` is sampled only in IDLE. A `start` in any other state increments `drop_cnt`, which saturates at 255 and is cleared only by `rst`. This includes the cycle in which the final byte is accepted.
- Address 0 is not decoded by the register file and is used as the idle address.
- Reset mid-packet: every output returns to its reset value immediately. The partial packet is abandoned and no `pkt_done` is generated.

## Timing
- Reset values: busy=0, addr=0, tx_data=0, tx_valid=0, pkt_done=0, drop_cnt=0; FSM in IDLE.
- `start` high at edge E: busy=1 and tx_valid=1 with tx_data=`SYNC_BYTE` from cycle E+1.
- Each payload byte costs at least 2 cycles (FETCH + SEND). SYNC, LEN and CHK each cost at least 1 cycle.
- With tx_ready tied high and defaults, counting cycles after the `start` edge:
  - SYNC in cycle 1, LEN in cycle 2.
  - Payload byte k (k=0..24): FETCH in cycle 3+2k, SEND in cycle 4+2k.
  - CHK in cycle 53.
  - `pkt_done` in cycle 54 with checksum in; cycle 53 with checksum out.
- `data` is sampled exactly one edge after `addr` changes; `addr` is stable throughout FETCH and SEND.

## Configuration
- Macro `SENSOR_READER_CHKSUM_EN`.
- Defined:
  - CHK state is present; the packet is LEN+3 bytes.
  - CHK is chosen so that (sum of payload bytes + CHK) mod 256 = 0. SYNC and LEN are excluded from the sum.
- Undefined:
  - CHK state and sum register are removed; the packet is LEN+2 bytes.
  - Finish follows acceptance of the last payload byte.

## Test plan
- Defaults, checksum on, tx_ready=1, register file loaded with address value = address (data=addr): expect stream A5, 19, 01..19 hex, then CHK=8'hBB (payload sum 0x145 → 0x45, two's complement 0xBB); pkt_done in cycle 54.
- Same stimulus with checksum off: 27 bytes ending at 0x19; pkt_done in cycle 53.
- tx_ready toggled by a pseudo-random pattern (~30% duty): identical byte sequence; tx_data never changes while tx_valid=1 and not accepted.
- `start` pulsed 300 times while busy: drop_cnt=255 (saturated); the current packet is unaffected.
- `rst` asserted during payload byte 10: outputs go to reset values at once with no pkt_done; a new `start` produces a complete packet beginning with A5.
- FIRST_ADDR=LAST_ADDR=4 with data=8'h80, checksum on: stream A5, 01, 80, 80; pkt_done follows.
